// File: rtl/slvdec_pkg.sv
// Shared constants, state encoding and helpers for the slave address decoder.
package slvdec_pkg;

    localparam logic [31:0] SLV_BASE   = 32'hFFEF_0200;
    localparam logic [31:0] SLV_MASK   = 32'hFFEF_0F00;
    localparam int          SLV_ID_LSB = 12;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } slvdec_state_t;

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/slvdec_decode.sv
// Combinational address decode: window match plus slave-id range check.
module slvdec_decode
    import slvdec_pkg::*;
#(
    parameter int NSLV = 16
) (
    input  logic [31:0] m_addr,
    output logic        hit,
    output logic [3:0]  id
);

    assign id  = m_addr[SLV_ID_LSB +: 4];
    // Bit 20 and the low byte fall outside the mask, so aliases decode alike.
    assign hit = ((m_addr & SLV_MASK) == SLV_BASE) && (int'(id) < NSLV);

endmodule

// File: rtl/slvdec.sv
// Sequences one arbitrated request at a time onto the slave array and
// returns a completion pulse with read data or a decode error.
module slvdec
    import slvdec_pkg::*;
#(
    parameter int NSLV = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      m_req,
    input  logic [31:0]               m_addr,
    input  logic                      m_rw,
    input  logic [31:0]               m_wdata,
    output logic                      m_ack,
    output logic                      m_err,
    output logic [31:0]               m_rdata,
    output logic [NSLV-1:0]           sel,
    output logic [31:0]               addr,
    output logic                      RW,
    output logic [31:0]               DataToSlave,
    input  logic [NSLV-1:0][31:0]     DataFromSlave,
    output logic [15:0]               txn_cnt,
    output logic [15:0]               err_cnt,
    output slvdec_state_t             dbg_state
);

    // Handshake: m_req is held with stable fields until m_ack; m_ack is a
    // one-cycle pulse and the requester drops m_req on the edge sampling it.

    slvdec_state_t state, next_state;
    logic          dec_hit;
    logic [3:0]    dec_id;
    logic [3:0]    id_q;
    logic          err_q;
    logic [31:0]   rd_mux;

    slvdec_decode #(.NSLV(NSLV)) u_decode (
        .m_addr (m_addr),
        .hit    (dec_hit),
        .id     (dec_id)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (m_req) next_state = dec_hit ? ISSUE : DONE;
            ISSUE:   next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        m_ack = (state == DONE);
        m_err = (state == DONE) && err_q;
        sel   = '0;
        if (state == ISSUE) begin
            for (int i = 0; i < NSLV; i++) sel[i] = (id_q == 4'(i));
        end
    end

    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NSLV; i++) begin
            if (id_q == 4'(i)) rd_mux = DataFromSlave[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr        <= '0;
            RW          <= 1'b0;
            DataToSlave <= '0;
            id_q        <= '0;
            err_q       <= 1'b0;
            m_rdata     <= '0;
            txn_cnt     <= '0;
            err_cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (m_req) begin
                        addr        <= m_addr;
                        RW          <= m_rw;
                        DataToSlave <= m_wdata;
                        id_q        <= dec_id;
                        err_q       <= !dec_hit;
                    end
                end
                ISSUE: begin
                    // Slave data is sampled on the same edge the slave advances.
                    if (!RW) m_rdata <= rd_mux;
                    txn_cnt <= sat_inc(txn_cnt);
                end
                DONE: begin
                    if (err_q) err_cnt <= sat_inc(err_cnt);
                end
                default: ;
            endcase
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_slvdec.sv
// Directed bench for slvdec: decode hits/misses, aliasing, async reset,
// read-data capture from counting slave models and counter saturation.
module tb_slvdec;
    import slvdec_pkg::*;

    logic              clk;
    logic              rst;
    logic              m_req;
    logic [31:0]       m_addr;
    logic              m_rw;
    logic [31:0]       m_wdata;
    logic              m_ack;
    logic              m_err;
    logic [31:0]       m_rdata;
    logic [15:0]       sel;
    logic [31:0]       addr;
    logic              rw_o;
    logic [31:0]       dts;
    logic [15:0][31:0] dfs;
    logic [15:0]       txn_cnt;
    logic [15:0]       err_cnt;
    slvdec_state_t     dbg_state;

    logic              m_req4;
    logic [31:0]       m_addr4;
    logic              m_ack4;
    logic              m_err4;
    logic [31:0]       m_rdata4;
    logic [3:0]        sel4;
    logic [31:0]       addr4;
    logic              rw4;
    logic [31:0]       dts4;
    logic [3:0][31:0]  dfs4;
    logic [15:0]       txn_cnt4;
    logic [15:0]       err_cnt4;
    slvdec_state_t     dbg_state4;

    int                checks;
    int                errors;
    logic [23:0]       ec [16];
    logic [15:0]       exp_txn;

    slvdec #(.NSLV(16)) dut (
        .clk(clk), .rst(rst), .m_req(m_req), .m_addr(m_addr), .m_rw(m_rw),
        .m_wdata(m_wdata), .m_ack(m_ack), .m_err(m_err), .m_rdata(m_rdata),
        .sel(sel), .addr(addr), .RW(rw_o), .DataToSlave(dts),
        .DataFromSlave(dfs), .txn_cnt(txn_cnt), .err_cnt(err_cnt),
        .dbg_state(dbg_state)
    );

    slvdec #(.NSLV(4)) dut4 (
        .clk(clk), .rst(rst), .m_req(m_req4), .m_addr(m_addr4), .m_rw(1'b0),
        .m_wdata(32'h0), .m_ack(m_ack4), .m_err(m_err4), .m_rdata(m_rdata4),
        .sel(sel4), .addr(addr4), .RW(rw4), .DataToSlave(dts4),
        .DataFromSlave(dfs4), .txn_cnt(txn_cnt4), .err_cnt(err_cnt4),
        .dbg_state(dbg_state4)
    );

    // Slave models: top byte is the slave id, low 24 bits count accesses.
    for (genvar g = 0; g < 16; g++) begin : g_slv
        logic [23:0] c;
        always_ff @(posedge clk or posedge rst) begin
            if (rst)         c <= '0;
            else if (sel[g]) c <= c + 24'd1;
        end
        assign dfs[g] = {8'(g), c};
    end

    assign dfs4 = {32'hA000_0003, 32'hA000_0002, 32'hA000_0001, 32'hA000_0000};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_read(input logic [3:0] id);
        m_req  = 1'b1;
        m_rw   = 1'b0;
        m_addr = {16'hFFEF, id, 4'h2, 8'($urandom_range(0, 255))};
        step();
        chk("loop_sel", 32'(sel), 32'(16'h1 << id));
        step();
        chk("loop_ack", 32'(m_ack), 32'd1);
        chk("loop_rdata", m_rdata, {8'(id), ec[id]});
        ec[id]  = ec[id] + 24'd1;
        exp_txn = (exp_txn == 16'hFFFF) ? exp_txn : exp_txn + 16'd1;
        chk("loop_txn", 32'(txn_cnt), 32'(exp_txn));
        m_req = 1'b0;
        step();
        chk("loop_idle_sel", 32'(sel), 32'd0);
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst     = 1'b1;
        m_req   = 1'b0;
        m_addr  = '0;
        m_rw    = 1'b0;
        m_wdata = '0;
        m_req4  = 1'b0;
        m_addr4 = '0;
        for (int i = 0; i < 16; i++) ec[i] = '0;

        #2;
        chk("rst_ack", 32'(m_ack), 32'd0);
        chk("rst_err", 32'(m_err), 32'd0);
        chk("rst_rdata", m_rdata, 32'd0);
        chk("rst_sel", 32'(sel), 32'd0);
        chk("rst_addr", addr, 32'd0);
        chk("rst_cnts", {txn_cnt, err_cnt}, 32'd0);
        chk("rst_state", 32'(dbg_state), 32'(IDLE));
        @(negedge clk);
        rst = 1'b0;
        step();

        // Write to slave 3.
        m_req = 1'b1; m_addr = 32'hFFEF_3210; m_rw = 1'b1; m_wdata = 32'h3000_0000;
        step();
        chk("wr_sel", 32'(sel), 32'h0008);
        chk("wr_rw", 32'(rw_o), 32'd1);
        chk("wr_dts", dts, 32'h3000_0000);
        chk("wr_ack_early", 32'(m_ack), 32'd0);
        chk("wr_state", 32'(dbg_state), 32'(ISSUE));
        step();
        chk("wr_ack", 32'(m_ack), 32'd1);
        chk("wr_err", 32'(m_err), 32'd0);
        chk("wr_sel_off", 32'(sel), 32'd0);
        chk("wr_txn", 32'(txn_cnt), 32'd1);
        chk("wr_rdata_kept", m_rdata, 32'd0);
        ec[3] = ec[3] + 24'd1;
        m_req = 1'b0;
        step();
        chk("wr_ack_off", 32'(m_ack), 32'd0);

        // Two reads of slave 5.
        m_req = 1'b1; m_addr = 32'hFFEF_5230; m_rw = 1'b0;
        step();
        chk("rd1_sel", 32'(sel), 32'h0020);
        chk("rd1_ack_early", 32'(m_ack), 32'd0);
        step();
        chk("rd1_ack", 32'(m_ack), 32'd1);
        chk("rd1_rdata", m_rdata, 32'h0500_0000);
        m_req = 1'b0;
        step();
        m_req = 1'b1;
        step();
        chk("rd2_sel", 32'(sel), 32'h0020);
        step();
        chk("rd2_ack", 32'(m_ack), 32'd1);
        chk("rd2_rdata", m_rdata, 32'h0500_0001);
        chk("rd2_txn", 32'(txn_cnt), 32'd3);
        ec[5] = 24'd2;
        m_req = 1'b0;
        step();

        // Decode miss.
        m_req = 1'b1; m_addr = 32'hFFEF_0300;
        step();
        chk("miss_ack", 32'(m_ack), 32'd1);
        chk("miss_err", 32'(m_err), 32'd1);
        chk("miss_sel", 32'(sel), 32'd0);
        m_req = 1'b0;
        step();
        chk("miss_errcnt", 32'(err_cnt), 32'd1);
        chk("miss_ack_off", 32'(m_ack), 32'd0);
        chk("miss_rdata", m_rdata, 32'h0500_0001);
        chk("miss_txn", 32'(txn_cnt), 32'd3);

        // Bit-20 alias decodes as slave 2.
        m_req = 1'b1; m_addr = 32'hFFFF_2200; m_rw = 1'b0;
        step();
        chk("alias_sel", 32'(sel), 32'h0004);
        step();
        chk("alias_err", 32'(m_err), 32'd0);
        chk("alias_rdata", m_rdata, 32'h0200_0000);
        chk("alias_txn", 32'(txn_cnt), 32'd4);
        ec[2] = ec[2] + 24'd1;
        m_req = 1'b0;
        step();

        // NSLV=4 instance: id 7 is out of range, id 3 is valid.
        m_req4 = 1'b1; m_addr4 = 32'hFFEF_7200;
        step();
        chk("n4_miss_ack", 32'(m_ack4), 32'd1);
        chk("n4_miss_err", 32'(m_err4), 32'd1);
        chk("n4_miss_sel", 32'(sel4), 32'd0);
        m_req4 = 1'b0;
        step();
        m_req4 = 1'b1; m_addr4 = 32'hFFEF_3200;
        step();
        chk("n4_hit_sel", 32'(sel4), 32'h8);
        step();
        chk("n4_hit_err", 32'(m_err4), 32'd0);
        chk("n4_hit_rdata", m_rdata4, 32'hA000_0003);
        m_req4 = 1'b0;
        step();

        // Reset while in ISSUE.
        m_req = 1'b1; m_addr = 32'hFFEF_1200; m_rw = 1'b0;
        step();
        chk("rsti_sel_before", 32'(sel), 32'h0002);
        #1 rst = 1'b1;
        #1;
        chk("rsti_sel", 32'(sel), 32'd0);
        chk("rsti_state", 32'(dbg_state), 32'(IDLE));
        chk("rsti_cnts", {txn_cnt, err_cnt}, 32'd0);
        chk("rsti_rdata", m_rdata, 32'd0);
        m_req = 1'b0;
        #1 rst = 1'b0;
        for (int i = 0; i < 16; i++) ec[i] = '0;
        step();
        chk("rsti_no_ack", 32'(m_ack), 32'd0);
        chk("rsti_txn", 32'(txn_cnt), 32'd0);

        // First request after reset completes normally.
        exp_txn = 16'd0;
        run_read(4'd5);

        // Preload the counter near the top, then run hits through saturation.
        force dut.txn_cnt = 16'hFFFD;
        #1 release dut.txn_cnt;
        exp_txn = 16'hFFFD;
        for (int k = 0; k < 6; k++) run_read(4'($urandom_range(0, 15)));
        chk("sat_final", 32'(txn_cnt), 32'h0000_FFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
